ddr3_app_initiator: RTL and testbench

User-side master for the DDR3 controller application interface. Converts a simple request/write-stream/read-stream protocol from core logic into `cmd`/`cmd_en`/`addr` commands, 128-bit write bursts and read-beat collection. It sits between core logic and the controller's app port and drives the controller signals the controller only samples. It gates all traffic on `init_calib_complete` and bounds read latency with a timeout.

---
 rtl/ddr3_app_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_ddr3_app_initiator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_app_initiator.sv
// ddr3_app_initiator
//   User-side master for the DDR3 controller application port. Accepts one
//   request at a time from core logic and turns it into a controller command,
//   then streams write beats through or collects read beats.
//   Traffic is gated on init_calib_complete. Read collection is bounded by a
//   timeout so a missing read beat cannot hang the initiator.
//
// Ports
//   memory_clk, rst_n         clock, asynchronous active-low reset
//   init_calib_complete       controller calibration done
//   req_*                     request handshake (we, addr, beats-1)
//   wdata_*, wmask            write-beat stream from core logic
//   rdata_valid/rdata/_last   read-beat stream to core logic (no backpressure)
//   done, err, busy           transaction status
//   cmd, cmd_en, addr,
//   app_burst_number, cmd_ready            controller command channel
//   wr_data*, wr_data_rdy                  controller write-data channel
//   rd_data, rd_data_valid, rd_data_end    controller read-data channel
module ddr3_app_initiator #(
  parameter int             ADDR_W  = 28,
  parameter int             DATA_W  = 128,
  parameter int             TIMEOUT = 1024,
  parameter logic [2:0]     CMD_WR  = 3'd0,
  parameter logic [2:0]     CMD_RD  = 3'd1
) (
  input  logic                  memory_clk,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [5:0]            req_beats,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wmask,
  output logic                  rdata_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            cmd,
  output logic                  cmd_en,
  output logic [ADDR_W-1:0]     addr,
  output logic [5:0]            app_burst_number,
  input  logic                  cmd_ready,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_data_mask,
  output logic                  wr_data_en,
  output logic                  wr_data_end,
  input  logic                  wr_data_rdy,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_data_valid,
  input  logic                  rd_data_end
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  localparam int            TW   = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [5:0]          beats_q, beats_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvld_q, rvld_d;
  logic                rlast_q, rlast_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wr_xfer;

  // Beat counting uses our own counter; the controller's end flag and the
  // forced-zero low address bits are intentionally not consumed.
  logic [3:0]          unused_bits;
  assign unused_bits = {rd_data_end, req_addr[2:0]};

  assign wr_xfer = (state_q == S_WDATA) & wdata_valid & wr_data_rdy;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    rlast_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_calib_complete) state_d = S_READY;
      end
      S_READY: begin
        if (!init_calib_complete) begin
          state_d = S_IDLE;
        end else if (req_valid) begin
          we_d    = req_we;
          addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
          beats_d = req_beats;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          state_d = we_q ? S_WDATA : S_RDATA;
          cnt_d   = 6'd0;
          tcnt_d  = '0;
        end
      end
      S_WDATA: begin
        if (wr_xfer) begin
          if (cnt_q == beats_q) begin
            state_d = S_READY;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_RDATA: begin
        // A beat arriving on the timeout cycle still counts and restarts the timer.
        if (rd_data_valid) begin
          rdata_d = rd_data;
          rvld_d  = 1'b1;
          tcnt_d  = '0;
          if (cnt_q == beats_q) begin
            rlast_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else if (tcnt_q == TMAX) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_READY;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b1;
      addr_q  <= '0;
      beats_q <= 6'd0;
      cnt_q   <= 6'd0;
      tcnt_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      rlast_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      rlast_q <= rlast_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready        = (state_q == S_READY) & init_calib_complete;
  assign busy             = (state_q == S_CMD) | (state_q == S_WDATA) | (state_q == S_RDATA);
  assign cmd_en           = (state_q == S_CMD);
  assign cmd              = we_q ? CMD_WR : CMD_RD;
  assign addr             = addr_q;
  assign app_burst_number = beats_q;
  assign wdata_ready      = (state_q == S_WDATA) & wr_data_rdy;
  assign wr_data_en       = wr_xfer;
  assign wr_data_end      = wr_xfer & (cnt_q == beats_q);
  assign wr_data          = wdata;
  assign wr_data_mask     = wmask;
  assign rdata_valid      = rvld_q;
  assign rdata            = rdata_q;
  assign rdata_last       = rlast_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_ddr3_app_initiator.sv
module tb_ddr3_app_initiator;

  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 1024;

  logic                 memory_clk = 1'b0;
  logic                 rst_n;
  logic                 init_calib_complete;
  logic                 req_valid, req_ready, req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [5:0]           req_beats;
  logic                 wdata_valid, wdata_ready;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W/8-1:0]  wmask;
  logic                 rdata_valid, rdata_last, done, err, busy;
  logic [DATA_W-1:0]    rdata;
  logic [2:0]           cmd;
  logic                 cmd_en, cmd_ready;
  logic [ADDR_W-1:0]    addr;
  logic [5:0]           app_burst_number;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W/8-1:0]  wr_data_mask;
  logic                 wr_data_en, wr_data_end, wr_data_rdy;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_data_valid, rd_data_end;

  int total = 0;
  int bad   = 0;

  always #5 memory_clk = ~memory_clk;

  ddr3_app_initiator dut (
    .memory_clk(memory_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_beats(req_beats),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wmask(wmask),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .err(err), .busy(busy),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .app_burst_number(app_burst_number),
    .cmd_ready(cmd_ready),
    .wr_data(wr_data), .wr_data_mask(wr_data_mask), .wr_data_en(wr_data_en),
    .wr_data_end(wr_data_end), .wr_data_rdy(wr_data_rdy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_end(rd_data_end)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nextcyc();
    @(posedge memory_clk);
    #1;
  endtask

  logic [DATA_W-1:0] wd [4];
  logic [DATA_W-1:0] rdv [8];

  initial begin
    int n, idx, cmd_cyc, got, sent, extra, done_at;
    bit prev_drove, drove, seen_rdy, seen_cmd, err_at, last_at;

    for (int k = 0; k < 4; k++) wd[k] = {4{32'hA5A50000 + 32'(k)}};
    for (int k = 0; k < 8; k++) rdv[k] = {4{32'hC0DE0000 + 32'(k)}};

    rst_n = 1'b0; init_calib_complete = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_beats = 6'd0;
    wdata_valid = 1'b0; wdata = '0; wmask = '0;
    cmd_ready = 1'b0; wr_data_rdy = 1'b0;
    rd_data = '0; rd_data_valid = 1'b0; rd_data_end = 1'b0;

    // Reset state
    repeat (2) nextcyc();
    @(negedge memory_clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_data_en", wr_data_en, 0);

    // Calibration gate with a pending single-beat write
    nextcyc();
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h0000013; req_beats = 6'd0;
    wdata = 128'h0123456789ABCDEF0123456789ABCDEF; wmask = '0; wdata_valid = 1'b1;
    wr_data_rdy = 1'b1; cmd_ready = 1'b1;
    seen_rdy = 0; seen_cmd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge memory_clk);
      if (req_ready) seen_rdy = 1;
      if (cmd_en) seen_cmd = 1;
      nextcyc();
    end
    chk("gate_req_ready", seen_rdy, 0);
    chk("gate_cmd_en", seen_cmd, 0);
    init_calib_complete = 1'b1;
    n = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge memory_clk);
      if (req_ready) begin n = c; break; end
      nextcyc();
    end
    chk("gate_accept_within_2", (n >= 1 && n <= 2), 1);

    // Single write
    nextcyc();
    req_valid = 1'b0;
    @(negedge memory_clk);
    chk("w1_cmd_en", cmd_en, 1);
    chk("w1_cmd", cmd, 0);
    chk("w1_addr", addr, 28'h0000010);
    chk("w1_burst", app_burst_number, 0);
    chk("w1_busy", busy, 1);
    chk("w1_no_early_beat", wr_data_en, 0);
    nextcyc();
    @(negedge memory_clk);
    chk("w1_wr_en", wr_data_en, 1);
    chk("w1_wr_end", wr_data_end, 1);
    chk("w1_wr_data", wr_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("w1_wr_mask", wr_data_mask, 0);
    nextcyc();
    @(negedge memory_clk);
    chk("w1_done", done, 1);
    chk("w1_err", err, 0);
    chk("w1_req_ready_b2b", req_ready, 1);
    chk("w1_no_extra_beat", wr_data_en, 0);
    nextcyc();
    wdata_valid = 1'b0;
    chk("w1_done_pulse", done, 0);

    // 4-beat write, wr_data_rdy toggling, cmd_ready low 3 cycles
    req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h0000105; req_beats = 6'd3;
    cmd_ready = 1'b0;
    nextcyc();
    req_valid = 1'b0;
    idx = 0; cmd_cyc = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      cmd_ready = (c >= 3);
      wr_data_rdy = c[0];
      wdata_valid = (idx < 4);
      wdata = wd[idx & 3];
      @(negedge memory_clk);
      if (cmd_en) begin
        cmd_cyc++;
        if (c == 0) chk("w4_addr", addr, 28'h0000100);
      end
      if (wr_data_en) begin
        chk("w4_data_order", wr_data, wd[idx & 3]);
        chk("w4_wr_end", wr_data_end, (idx == 3));
        idx++;
      end
      if (done) begin n = 1; break; end
      nextcyc();
    end
    chk("w4_cmd_cycles", cmd_cyc, 4);
    chk("w4_beats", idx, 4);
    chk("w4_done_seen", n, 1);
    nextcyc();
    wdata_valid = 1'b0; wr_data_rdy = 1'b1; cmd_ready = 1'b1;

    // 8-beat read, beats every 3 cycles
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000200; req_beats = 6'd7;
    nextcyc();
    req_valid = 1'b0;
    @(negedge memory_clk);
    chk("r8_cmd", cmd, 1);
    nextcyc();
    got = 0; sent = 0; prev_drove = 0; n = 0;
    for (int c = 0; c < 60; c++) begin
      drove = (c % 3 == 0) && (sent < 8);
      rd_data_valid = drove;
      rd_data = rdv[sent & 7];
      @(negedge memory_clk);
      if (rdata_valid) begin
        chk("r8_latency", prev_drove, 1);
        chk("r8_data", rdata, rdv[got & 7]);
        chk("r8_last", rdata_last, (got == 7));
        chk("r8_done", done, (got == 7));
        chk("r8_err", err, 0);
        got++;
      end else if (done) begin
        chk("r8_done_without_beat", done, 0);
      end
      if (got == 8) begin n = 1; break; end
      prev_drove = drove;
      if (drove) sent++;
      nextcyc();
    end
    chk("r8_beats", got, 8);
    nextcyc();
    rd_data_valid = 1'b0;

    // Read timeout: 3+1 beats requested, two returned
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000400; req_beats = 6'd3;
    nextcyc();
    req_valid = 1'b0;
    nextcyc();
    for (int c = 0; c < 2; c++) begin
      rd_data_valid = 1'b1;
      rd_data = rdv[c];
      nextcyc();
    end
    rd_data_valid = 1'b0;
    done_at = -1; extra = 0; err_at = 0; last_at = 1;
    for (int k = 0; k < TIMEOUT + 20; k++) begin
      @(negedge memory_clk);
      if (k == 0) chk("to_beat2", rdata_valid, 1);
      else if (rdata_valid) extra++;
      if (done) begin
        done_at = k; err_at = err; last_at = rdata_last;
        break;
      end
      nextcyc();
    end
    chk("to_done_cycle", done_at, TIMEOUT);
    chk("to_err", err_at, 1);
    chk("to_no_last", last_at, 0);
    chk("to_no_extra", extra, 0);
    nextcyc();
    rd_data_valid = 1'b1; rd_data = 128'hDEAD;
    nextcyc();
    rd_data_valid = 1'b0;
    @(negedge memory_clk);
    chk("to_late_dropped", rdata_valid, 0);
    chk("to_late_rdata", rdata, rdv[1]);
    chk("to_ready_again", req_ready, 1);

    // Next request accepted, then reset in WDATA after 1 of 4 beats
    req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h0000300; req_beats = 6'd3;
    nextcyc();
    req_valid = 1'b0;
    @(negedge memory_clk);
    chk("rs_cmd_en", cmd_en, 1);
    chk("rs_cmd", cmd, 0);
    nextcyc();
    wdata_valid = 1'b1; wdata = wd[0];
    @(negedge memory_clk);
    chk("rs_beat1", wr_data_en, 1);
    chk("rs_beat1_end", wr_data_end, 0);
    nextcyc();
    wdata_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_cmd_en0", cmd_en, 0);
    chk("rs_wdata_ready", wdata_ready, 0);
    chk("rs_req_ready", req_ready, 0);
    chk("rs_done", done, 0);
    chk("rs_addr", addr, 0);
    chk("rs_burst", app_burst_number, 0);
    nextcyc();
    nextcyc();
    rst_n = 1'b1;
    nextcyc();
    @(negedge memory_clk);
    chk("rs_back_ready", req_ready, 1);
    chk("rs_no_done", done, 0);
    chk("rs_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
